// File: rtl/w_writeback_grf.sv
// Writeback stage: selects the writeback datum, commits it to the 32x32 register file
// with same-cycle read bypass, counts retired instructions and keeps a one-cycle commit trace.
module w_writeback_grf #(
   parameter logic [31:0] LINK_OFFSET    = 32'd8,
   parameter logic [31:0] RESET_TRACE_PC = 32'h00003000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] W_ALU_O,
   input  logic [31:0] W_DM_O,
   input  logic [31:0] W_PC,
   input  logic [31:0] W_EXT_O,
   input  logic [31:0] W_CMP_O,
   input  logic [31:0] W_MUXMDSrc_O,
   input  logic [31:0] W_CP0_O,
   input  logic [4:0]  W_A3,
   input  logic [2:0]  W_WDSel,
   input  logic        W_RegWrite,
   input  logic        W_valid,
   input  logic [4:0]  D_A1,
   input  logic [4:0]  D_A2,
   output logic [31:0] D_RD1,
   output logic [31:0] D_RD2,
   output logic [31:0] W_WD,
   output logic [31:0] retired,
   output logic        commit_we,
   output logic [31:0] commit_pc,
   output logic [4:0]  commit_addr,
   output logic [31:0] commit_data
);

   logic [31:0] r_grf [0:31];
   logic [31:0] r_retired;
   logic        r_commit_we;
   logic [31:0] r_commit_pc;
   logic [4:0]  r_commit_addr;
   logic [31:0] r_commit_data;
   logic        w_we;
   logic [31:0] w_wd;

   always_comb begin
      w_wd = 32'h0;
      case (W_WDSel)
         3'd0:    w_wd = W_ALU_O;
         3'd1:    w_wd = W_DM_O;
         3'd2:    w_wd = W_PC + LINK_OFFSET;
         3'd3:    w_wd = W_EXT_O;
         3'd4:    w_wd = W_CMP_O;
         3'd5:    w_wd = W_MUXMDSrc_O;
         3'd6:    w_wd = W_CP0_O;
         default: w_wd = 32'h0;
      endcase
   end

   // Gating with reset keeps the bypass from exposing a write that is being discarded.
   assign w_we = W_RegWrite & W_valid & (W_A3 != 5'd0) & ~reset;

   always_comb begin
      D_RD1 = 32'h0;
      if (D_A1 == 5'd0)
         D_RD1 = 32'h0;
      else if (w_we && (D_A1 == W_A3))
         D_RD1 = w_wd;
      else
         D_RD1 = r_grf[D_A1];
   end

   always_comb begin
      D_RD2 = 32'h0;
      if (D_A2 == 5'd0)
         D_RD2 = 32'h0;
      else if (w_we && (D_A2 == W_A3))
         D_RD2 = w_wd;
      else
         D_RD2 = r_grf[D_A2];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 32; i++)
            r_grf[i] <= 32'h0;
      end else if (w_we) begin
         r_grf[W_A3] <= w_wd;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_retired <= 32'h0;
      else if (W_valid)
         r_retired <= r_retired + 32'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_commit_we   <= 1'b0;
         r_commit_pc   <= RESET_TRACE_PC;
         r_commit_addr <= 5'd0;
         r_commit_data <= 32'h0;
      end else begin
         r_commit_we <= w_we;
         if (w_we) begin
            r_commit_pc   <= W_PC;
            r_commit_addr <= W_A3;
            r_commit_data <= w_wd;
         end
      end
   end

   assign W_WD        = w_wd;
   assign retired     = r_retired;
   assign commit_we   = r_commit_we;
   assign commit_pc   = r_commit_pc;
   assign commit_addr = r_commit_addr;
   assign commit_data = r_commit_data;

endmodule

// File: tb/tb_w_writeback_grf.sv
// Directed bench for w_writeback_grf: table of writeback-select vectors plus
// hand-written sequences for zero-register, bubble, counter wrap and async reset.
module tb_w_writeback_grf;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] W_ALU_O, W_DM_O, W_PC, W_EXT_O, W_CMP_O, W_MUXMDSrc_O, W_CP0_O;
   logic [4:0]  W_A3, D_A1, D_A2;
   logic [2:0]  W_WDSel;
   logic        W_RegWrite, W_valid;
   logic [31:0] D_RD1, D_RD2, W_WD, retired, commit_pc, commit_data;
   logic        commit_we;
   logic [4:0]  commit_addr;

   int checks = 0;
   int failures = 0;
   logic [31:0] exp_ret;

   typedef struct {
      logic [2:0]  sel;
      logic [4:0]  a3;
      logic [31:0] exp;
   } vec_t;
   vec_t tbl [8];

   w_writeback_grf dut (
      .clk(clk), .reset(reset),
      .W_ALU_O(W_ALU_O), .W_DM_O(W_DM_O), .W_PC(W_PC), .W_EXT_O(W_EXT_O),
      .W_CMP_O(W_CMP_O), .W_MUXMDSrc_O(W_MUXMDSrc_O), .W_CP0_O(W_CP0_O),
      .W_A3(W_A3), .W_WDSel(W_WDSel), .W_RegWrite(W_RegWrite), .W_valid(W_valid),
      .D_A1(D_A1), .D_A2(D_A2), .D_RD1(D_RD1), .D_RD2(D_RD2), .W_WD(W_WD),
      .retired(retired), .commit_we(commit_we), .commit_pc(commit_pc),
      .commit_addr(commit_addr), .commit_data(commit_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic rw, input logic [4:0] a3,
                        input logic [2:0] sel);
      W_valid = v; W_RegWrite = rw; W_A3 = a3; W_WDSel = sel;
   endtask

   // Advance one clock edge, tracking the expected retired count.
   task automatic tick();
      @(posedge clk);
      if (W_valid && !reset) exp_ret = exp_ret + 32'd1;
      #1;
   endtask

   initial begin
      tbl[0] = '{3'd0, 5'd1, 32'h11111111};
      tbl[1] = '{3'd1, 5'd2, 32'h22222222};
      tbl[2] = '{3'd2, 5'd3, 32'h00003018};
      tbl[3] = '{3'd3, 5'd4, 32'h44444444};
      tbl[4] = '{3'd4, 5'd5, 32'h00000001};
      tbl[5] = '{3'd5, 5'd6, 32'h66666666};
      tbl[6] = '{3'd6, 5'd7, 32'h77777777};
      tbl[7] = '{3'd7, 5'd8, 32'h00000000};

      reset = 1'b1;
      W_ALU_O = 0; W_DM_O = 0; W_PC = 0; W_EXT_O = 0; W_CMP_O = 0;
      W_MUXMDSrc_O = 0; W_CP0_O = 0; D_A1 = 0; D_A2 = 0;
      drive(1'b0, 1'b0, 5'd0, 3'd0);
      exp_ret = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Reset state
      for (int a = 0; a < 32; a++) begin
         D_A1 = a[4:0]; D_A2 = 5'(31 - a); #1;
         check($sformatf("reset_rd1[%0d]", a), D_RD1, 32'h0);
         check($sformatf("reset_rd2[%0d]", 31 - a), D_RD2, 32'h0);
      end
      check("reset_commit_pc", commit_pc, 32'h00003000);
      check("reset_retired", retired, 32'h0);
      check("reset_commit_we", {31'h0, commit_we}, 32'h0);

      // Single write with same-cycle bypass
      @(negedge clk);
      W_ALU_O = 32'h1234; W_PC = 32'h3004; D_A1 = 5'd5; D_A2 = 5'd5;
      drive(1'b1, 1'b1, 5'd5, 3'd0);
      #1;
      check("bypass_rd1", D_RD1, 32'h1234);
      check("bypass_rd2", D_RD2, 32'h1234);
      tick();
      drive(1'b0, 1'b0, 5'd0, 3'd0);
      #1;
      check("storage_rd1", D_RD1, 32'h1234);
      check("trace_we", {31'h0, commit_we}, 32'h1);
      check("trace_addr", {27'h0, commit_addr}, 32'd5);
      check("trace_data", commit_data, 32'h1234);
      check("trace_pc", commit_pc, 32'h3004);
      check("retired_1", retired, exp_ret);

      // Writeback select table
      W_ALU_O = 32'h11111111; W_DM_O = 32'h22222222; W_PC = 32'h3010;
      W_EXT_O = 32'h44444444; W_CMP_O = 32'h00000001;
      W_MUXMDSrc_O = 32'h66666666; W_CP0_O = 32'h77777777;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         drive(1'b1, 1'b1, tbl[i].a3, tbl[i].sel);
         D_A1 = tbl[i].a3; D_A2 = 5'd0;
         #1;
         check($sformatf("wd_sel%0d", i), W_WD, tbl[i].exp);
         check($sformatf("bypass_sel%0d", i), D_RD1, tbl[i].exp);
         tick();
         check($sformatf("trace_data_sel%0d", i), commit_data, tbl[i].exp);
         check($sformatf("trace_addr_sel%0d", i), {27'h0, commit_addr}, {27'h0, tbl[i].a3});
      end
      @(negedge clk);
      drive(1'b0, 1'b0, 5'd0, 3'd0);
      for (int i = 0; i < 8; i++) begin
         D_A2 = tbl[i].a3; #1;
         check($sformatf("readback_r%0d", i + 1), D_RD2, tbl[i].exp);
      end

      // Writes to $0 are dropped but still retire
      @(negedge clk);
      W_ALU_O = 32'hDEAD; D_A1 = 5'd0;
      drive(1'b1, 1'b1, 5'd0, 3'd0);
      #1;
      check("r0_no_bypass", D_RD1, 32'h0);
      tick();
      check("r0_commit_we", {31'h0, commit_we}, 32'h0);
      check("r0_retired", retired, exp_ret);
      drive(1'b0, 1'b0, 5'd0, 3'd0);
      #1;
      check("r0_storage", D_RD1, 32'h0);

      // Bubble with RegWrite set: no write, no count
      @(negedge clk);
      W_ALU_O = 32'h9999; D_A1 = 5'd9;
      drive(1'b1, 1'b1, 5'd9, 3'd0);
      tick();
      @(negedge clk);
      W_ALU_O = 32'hBADBAD;
      drive(1'b0, 1'b1, 5'd9, 3'd0);
      #1;
      check("bubble_no_bypass", D_RD1, 32'h9999);
      tick();
      check("bubble_reg9", D_RD1, 32'h9999);
      check("bubble_retired", retired, exp_ret);
      check("bubble_commit_we", {31'h0, commit_we}, 32'h0);

      // Counter wrap via force hook
      @(negedge clk);
      drive(1'b0, 1'b0, 5'd0, 3'd0);
      force dut.r_retired = 32'hFFFFFFFF;
      #1;
      release dut.r_retired;
      #1;
      check("wrap_preload", retired, 32'hFFFFFFFF);
      drive(1'b1, 1'b0, 5'd0, 3'd0);
      @(posedge clk); #1;
      check("wrap_to_zero", retired, 32'h0);
      exp_ret = 32'h0;

      // Async reset in the middle of a write
      @(negedge clk);
      W_ALU_O = 32'hAAAA; D_A1 = 5'd3;
      drive(1'b1, 1'b1, 5'd3, 3'd0);
      tick();
      @(negedge clk);
      W_ALU_O = 32'hBBBB;
      #1;
      check("pre_reset_bypass", D_RD1, 32'hBBBB);
      #2;
      reset = 1'b1;
      #1;
      check("async_reset_reg3", D_RD1, 32'h0);
      check("async_reset_retired", retired, 32'h0);
      check("async_reset_commit_pc", commit_pc, 32'h00003000);
      exp_ret = 32'h0;
      @(posedge clk); #1;
      check("reset_blocks_write", D_RD1, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      drive(1'b0, 1'b0, 5'd0, 3'd0);
      tick();
      check("post_reset_reg3", D_RD1, 32'h0);
      check("post_reset_retired", retired, exp_ret);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
